cla_adder_pipe: RTL

//  Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the 16-bit CLA.

---
 rtl/cla_adder_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves one bit slice from the carry registered by the stage before it.
module cla_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SL = WIDTH / STAGES;
    localparam int NG = SL / BLOCK;

    logic [WIDTH-1:0] bx;
    logic             c0;

    assign bx = b ^ {WIDTH{sub}};
    assign c0 = cin ^ sub;

    // Group G/P give the carry into the next group; bit carries stay within a group.
    function automatic logic [SL:0] resolve(
        input logic [SL-1:0] x,
        input logic [SL-1:0] y,
        input logic          ci
    );
        logic [SL-1:0] g;
        logic [SL-1:0] p;
        logic [SL-1:0] s;
        logic          c;
        logic          gc;
        logic          gg;
        logic          gp;
        g = x & y;
        p = x ^ y;
        s = '0;
        c = ci;
        for (int i = 0; i < NG; i++) begin
            gg = 1'b0;
            gp = 1'b1;
            gc = c;
            for (int j = 0; j < BLOCK; j++) begin
                s[i*BLOCK+j] = p[i*BLOCK+j] ^ gc;
                gc = g[i*BLOCK+j] | (p[i*BLOCK+j] & gc);
                gg = g[i*BLOCK+j] | (p[i*BLOCK+j] & gg);
                gp = gp & p[i*BLOCK+j];
            end
            c = gg | (gp & c);
        end
        return {c, s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int SW = (k + 1) * SL;

        logic [SL-1:0] xa;
        logic [SL-1:0] xb;
        logic          xc;
        logic          src_v;
        logic [SW-1:0] s_d;
        logic [SL:0]   r;
        logic          adv;
        logic          v_q;
        logic          c_q;
        logic [SW-1:0] s_q;

        if (k == 0) begin : g_in
            assign src_v = in_valid;
            assign xa    = a[SL-1:0];
            assign xb    = bx[SL-1:0];
            assign xc    = c0;
            assign s_d   = r[SL-1:0];
        end else begin : g_in
            assign src_v = g_st[k-1].v_q;
            assign xa    = g_st[k-1].g_op.ra_q[SL-1:0];
            assign xb    = g_st[k-1].g_op.rb_q[SL-1:0];
            assign xc    = g_st[k-1].c_q;
            assign s_d   = {r[SL-1:0], g_st[k-1].s_q};
        end

        assign r = resolve(xa, xb, xc);

        if (k == STAGES - 1) begin : g_adv
            assign adv = !v_q || out_ready;
        end else begin : g_adv
            assign adv = !v_q || g_st[k+1].adv;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= src_v;
                if (src_v) begin
                    c_q <= r[SL];
                    s_q <= s_d;
                end
            end
        end

        // Unresolved upper operand bits travel with the op.
        if (k < STAGES - 1) begin : g_op
            localparam int RW = WIDTH - SW;
            logic [RW-1:0] ra_d;
            logic [RW-1:0] rb_d;
            logic [RW-1:0] ra_q;
            logic [RW-1:0] rb_q;

            if (k == 0) begin : g_src
                assign ra_d = a[WIDTH-1:SL];
                assign rb_d = bx[WIDTH-1:SL];
            end else begin : g_src
                assign ra_d = g_st[k-1].g_op.ra_q[WIDTH-k*SL-1:SL];
                assign rb_d = g_st[k-1].g_op.rb_q[WIDTH-k*SL-1:SL];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else if (adv && src_v) begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic o_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_q <= 1'b0;
                end else if (adv && src_v) begin
                    o_q <= (xa[SL-1] == xb[SL-1]) && (r[SL-1] != xa[SL-1]);
                end
            end
        end
    end

    assign in_ready  = g_st[0].adv;
    assign out_valid = g_st[STAGES-1].v_q;
    assign sum       = g_st[STAGES-1].s_q;
    assign cout      = g_st[STAGES-1].c_q;
    assign ovf       = g_st[STAGES-1].g_last.o_q;

endmodule
